// File: rtl/ysyx_23060236_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, funct3 access codes
// and helpers that decode access size and signedness.
package ysyx_23060236_lsu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRreq,
        StRwait,
        StWreq,
        StBwait,
        StDone
    } lsu_state_e;

    typedef enum logic [1:0] {
        SzByte,
        SzHalf,
        SzWord
    } lsu_size_e;

    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    // Unsigned codes only exist for loads; on a store they fall back to word.
    function automatic lsu_size_e f3_size(input logic [2:0] f3, input logic is_load);
        lsu_size_e sz;
        case (f3)
            F3Byte:  sz = SzByte;
            F3Half:  sz = SzHalf;
            F3Word:  sz = SzWord;
            F3ByteU: sz = is_load ? SzByte : SzWord;
            F3HalfU: sz = is_load ? SzHalf : SzWord;
            default: sz = SzWord;
        endcase
        return sz;
    endfunction

    function automatic logic f3_signed(input logic [2:0] f3);
        return (f3 == F3Byte) || (f3 == F3Half);
    endfunction

endpackage

// File: rtl/ysyx_23060236_lsu_align.sv
// Byte-lane steering: store strobe/data replication and load extraction with
// sign or zero extension. Purely combinational.
module ysyx_23060236_lsu_align
    import ysyx_23060236_lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_is_load,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_sdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);

    lsu_size_e   w_size;
    logic        w_sign;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_size = f3_size(i_funct3, i_is_load);
    assign w_sign = f3_signed(i_funct3);
    assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
    assign w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];

    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_sdata;
        o_ldata = i_rdata;
        case (w_size)
            SzByte: begin
                o_wstrb = 4'b0001 << i_offset;
                o_wdata = {4{i_sdata[7:0]}};
                o_ldata = {{24{w_sign & w_byte[7]}}, w_byte};
            end
            SzHalf: begin
                o_wstrb = 4'b0011 << {i_offset[1], 1'b0};
                o_wdata = {2{i_sdata[15:0]}};
                o_ldata = {{16{w_sign & w_half[15]}}, w_half};
            end
            default: begin
                o_wstrb = 4'b1111;
                o_wdata = i_sdata;
                o_ldata = i_rdata;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060236_lsu.sv
// Load/store unit: accepts one instruction at a time from execute, runs a single
// AXI-lite style read or write transaction, and hands the result to writeback.
module ysyx_23060236_lsu
    import ysyx_23060236_lsu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic        i_ren,
    input  logic        i_wen,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_sdata,
    input  logic [4:0]  i_rd,
    input  logic        i_reg_wen,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [4:0]  o_out_rd,
    output logic        o_out_wen,
    output logic [31:0] o_out_data,
    output logic        o_lsu_over,
    output logic        o_bus_err,
    output logic        o_arvalid,
    input  logic        i_arready,
    output logic [31:0] o_araddr,
    input  logic        i_rvalid,
    output logic        o_rready,
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_rresp,
    output logic        o_awvalid,
    input  logic        i_awready,
    output logic [31:0] o_awaddr,
    output logic        o_wvalid,
    input  logic        i_wready,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    input  logic        i_bvalid,
    output logic        o_bready,
    input  logic [1:0]  i_bresp
);

    lsu_state_e  r_state;
    lsu_state_e  w_state_next;
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_reg_wen;
    logic        r_is_store;
    logic [31:0] r_out_data;
    logic        r_aw_done;
    logic        r_w_done;
    logic [31:0] w_ldata;

    ysyx_23060236_lsu_align u_align (
        .i_funct3  (r_funct3),
        .i_is_load (~r_is_store),
        .i_offset  (r_addr[1:0]),
        .i_sdata   (r_sdata),
        .i_rdata   (i_rdata),
        .o_wstrb   (o_wstrb),
        .o_wdata   (o_wdata),
        .o_ldata   (w_ldata)
    );

    assign o_araddr   = {r_addr[31:2], 2'b00};
    assign o_awaddr   = {r_addr[31:2], 2'b00};
    assign o_out_rd   = r_rd;
    assign o_out_wen  = r_reg_wen & ~r_is_store;
    assign o_out_data = r_out_data;

    always_ff @(posedge clock) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        o_in_ready   = 1'b0;
        o_arvalid    = 1'b0;
        o_rready     = 1'b0;
        o_awvalid    = 1'b0;
        o_wvalid     = 1'b0;
        o_bready     = 1'b0;
        o_out_valid  = 1'b0;
        o_lsu_over   = 1'b0;
        o_bus_err    = 1'b0;
        case (r_state)
            StIdle: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    if (i_ren)      w_state_next = StRreq;
                    else if (i_wen) w_state_next = StWreq;
                    else            w_state_next = StDone;
                end
            end
            StRreq: begin
                o_arvalid = 1'b1;
                if (i_arready) w_state_next = StRwait;
            end
            StRwait: begin
                o_rready = 1'b1;
                if (i_rvalid) begin
                    o_bus_err    = |i_rresp;
                    w_state_next = StDone;
                end
            end
            StWreq: begin
                // Each channel drops its valid once its own handshake has happened.
                o_awvalid = ~r_aw_done;
                o_wvalid  = ~r_w_done;
                if ((r_aw_done | i_awready) && (r_w_done | i_wready)) w_state_next = StBwait;
            end
            StBwait: begin
                o_bready = 1'b1;
                if (i_bvalid) begin
                    o_bus_err    = |i_bresp;
                    w_state_next = StDone;
                end
            end
            StDone: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    o_lsu_over   = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr     <= '0;
            r_sdata    <= '0;
            r_funct3   <= '0;
            r_rd       <= '0;
            r_reg_wen  <= 1'b0;
            r_is_store <= 1'b0;
            r_out_data <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            if (o_in_ready && i_in_valid) begin
                r_addr     <= i_addr;
                r_sdata    <= i_sdata;
                r_funct3   <= i_funct3;
                r_rd       <= i_rd;
                r_reg_wen  <= i_reg_wen;
                r_is_store <= i_wen & ~i_ren;
                r_aw_done  <= 1'b0;
                r_w_done   <= 1'b0;
                if (!i_ren) r_out_data <= i_wen ? 32'h0 : i_addr;
            end
            if (o_awvalid && i_awready) r_aw_done <= 1'b1;
            if (o_wvalid && i_wready)   r_w_done  <= 1'b1;
            if (o_rready && i_rvalid)   r_out_data <= w_ldata;
        end
    end

endmodule

// File: doc/ysyx_23060236_lsu.md
YSYX_23060236_LSU -- requirements
Module: ysyx_23060236_lsu

Interface
REQ-001 clock  in  1  system clock; all state on rising edge.
REQ-002 reset  in  1  synchronous, active-high.
REQ-003 in_valid / in_ready  in / out  1 / 1  upstream (execute) handshake; transfer when both high.
REQ-004 ren, wen  in  1 each  load / store request; both low = non-memory instruction (pass-through).
REQ-005 funct3  in  3  access size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
REQ-006 addr  in  32  byte address for memory ops; result value for pass-through.
REQ-007 sdata  in  32  store data, LSB-aligned.
REQ-008 rd, reg_wen  in  5, 1  destination register and write enable, carried to output.
REQ-009 out_valid / out_ready  out / in  1 / 1  downstream (writeback) handshake.
REQ-010 out_rd, out_wen, out_data  out  5, 1, 32  writeback fields; out_wen forced 0 for stores.
REQ-011 lsu_over  out  1  one-cycle pulse when an instruction leaves via the out handshake.
REQ-012 bus_err  out  1  one-cycle pulse when a completed transaction returned resp != 0.
REQ-013 AR channel  arvalid out 1, arready in 1, araddr out 32 (word-aligned: addr[31:2],2'b00).
REQ-014 R channel  rvalid in 1, rready out 1, rdata in 32, rresp in 2.
REQ-015 AW/W channels  awvalid, wvalid out 1; awready, wready in 1; awaddr out 32 (word-aligned); wdata out 32; wstrb out 4.
REQ-016 B channel  bvalid in 1, bready out 1, bresp in 2.

Function
REQ-017 FSM states SHALL be IDLE, RREQ, RWAIT, WREQ, BWAIT, DONE.
REQ-018 in_ready SHALL be 1 only in IDLE; accepted fields SHALL be registered on acceptance.
REQ-019 IDLE accept: ren -> RREQ; wen -> WREQ; neither -> DONE with out_data = addr; ren&wen together SHALL be treated as load.
REQ-020 RREQ: arvalid=1 until arready; then RWAIT. araddr SHALL stay stable while arvalid high.
REQ-021 RWAIT: rready=1; on rvalid capture extended load data, go DONE.
REQ-022 WREQ: awvalid and wvalid both asserted; each SHALL drop independently after its own ready; go BWAIT once both handshakes done (same or different cycles).
REQ-023 BWAIT: bready=1; on bvalid go DONE.
REQ-024 DONE: out_valid=1 with stable fields until out_ready; on handshake lsu_over=1 that cycle, return to IDLE.
REQ-025 Minimum latency acceptance->out_valid: pass-through 1 cycle; load with zero-wait bus 3 cycles.
REQ-026 Byte lane = addr[1:0]; sb: wstrb = 0001<<addr[1:0], wdata = byte replicated x4; sh: wstrb = 0011<<{addr[1],0}, wdata = half replicated x2; sw: wstrb = 1111.
REQ-027 Load extract: byte at rdata[8*addr[1:0]+:8], half at rdata[16*addr[1]+:16]; lb/lh sign-extend, lbu/lhu zero-extend, lw unchanged.
REQ-028 Misalignment SHALL NOT be checked; addr[0] ignored for halves, addr[1:0] ignored for words.
REQ-029 rresp/bresp != 0: bus_err pulses on the R/B handshake cycle; instruction SHALL still complete normally (load data as returned).
REQ-030 Undefined funct3 SHALL behave as word access.
REQ-031 Exactly one outstanding transaction; no new request issued before the previous response.

Reset
REQ-032 Reset SHALL force IDLE; all valid/ready outputs 0 except in_ready=1; lsu_over=0, bus_err=0.
REQ-033 Data registers (out_data, out_rd, addr/wdata latches) SHALL reset to 0.
REQ-034 Reset mid-transaction SHALL abandon it immediately; late bus responses after reset SHALL be ignored (ready low in IDLE).

Structure
REQ-035 Package ysyx_23060236_lsu_pkg SHALL hold the state encoding and funct3 size/sign constants.
REQ-036 Byte-lane logic (wstrb/wdata replication, load extraction/extension) SHALL be one combinational sub-module ysyx_23060236_lsu_align.

Verification
REQ-037 Pass-through: addr=0x1234, ren=wen=0, reg_wen=1, out_ready=1 -> out_valid next cycle, out_data=0x1234, lsu_over one pulse, no bus activity.
REQ-038 lb at 0x8000_0003, rdata=0x80FF_0011 -> araddr=0x8000_0000, out_data=0xFFFF_FF80; lbu same -> 0x0000_0080.
REQ-039 sh at 0x8000_0002, sdata=0xABCD -> wstrb=1100, wdata=0xABCD_ABCD, out_wen=0.
REQ-040 AW ready 1 cycle, W ready 3 cycles later -> each valid drops after its own handshake; BWAIT entered only after both.
REQ-041 out_ready held 0 for 4 cycles in DONE -> fields stable, in_ready=0, single lsu_over on release.
REQ-042 Reset asserted in RWAIT, then rvalid=1 -> IDLE, rready=0, no out_valid, no bus_err.
